// File: rtl/vdma_controller_pkg.sv
// Shared types for the vector DMA controller: FSM state encoding and transfer direction.
package vdma_controller_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SRC      = 3'd1,
        SRC_WAIT = 3'd2,
        DST      = 3'd3,
        DONE     = 3'd4
    } state_t;

    typedef enum logic {
        DIR_M2L = 1'b0,
        DIR_L2M = 1'b1
    } dir_t;

endpackage

// File: rtl/vdma_controller.sv
// Word-at-a-time DMA between main memory and a lane-local memory.
// One FSM with registered outputs; addresses and count live in the same block.
module vdma_controller
    import vdma_controller_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int LANE_AWIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dma_en,
    input  logic                   dma_we,
    input  logic [WIDTH-1:0]       mem_addr,
    input  logic [WIDTH-1:0]       lane_addr,
    input  logic [WIDTH-1:0]       num_bytes,
    output logic                   dma_busy,
    output logic                   dma_done,
    output logic                   m_req,
    output logic                   m_we,
    output logic [WIDTH-1:0]       m_addr,
    output logic [WIDTH-1:0]       m_wdata,
    input  logic [WIDTH-1:0]       m_rdata,
    input  logic                   m_ack,
    output logic                   l_en,
    output logic                   l_we,
    output logic [LANE_AWIDTH-1:0] l_addr,
    output logic [WIDTH-1:0]       l_wdata,
    input  logic [WIDTH-1:0]       l_rdata
);

    state_t           state;
    dir_t             dir;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] data;
    logic             en_q;
    logic             got;
    logic             start;
    logic             step;
    logic [WIDTH-1:0] words;
    logic             unused;

    assign words   = num_bytes >> 2;
    assign start   = dma_en && !en_q && (words != '0);
    // A word is finished in DST: immediately for lane writes, on m_ack for memory writes.
    assign step    = (state == DST) && ((dir == DIR_M2L) || m_ack);
    assign m_wdata = data;
    assign l_wdata = data;
    assign unused  = ^{lane_addr[WIDTH-1:LANE_AWIDTH+2], lane_addr[1:0], num_bytes[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            dir      <= DIR_M2L;
            cnt      <= '0;
            data     <= '0;
            en_q     <= 1'b0;
            got      <= 1'b0;
            dma_busy <= 1'b0;
            dma_done <= 1'b0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            l_en     <= 1'b0;
            l_we     <= 1'b0;
            l_addr   <= '0;
        end else begin
            en_q <= dma_en;
            case (state)
                IDLE: begin
                    if (start) begin
                        dir      <= dir_t'(dma_we);
                        m_addr   <= mem_addr;
                        l_addr   <= lane_addr[LANE_AWIDTH+1:2];
                        cnt      <= words;
                        dma_busy <= 1'b1;
                        state    <= SRC;
                        if (dma_we) begin
                            l_en <= 1'b1;
                        end else begin
                            m_req <= 1'b1;
                            m_we  <= 1'b0;
                        end
                    end
                end
                SRC: begin
                    state <= SRC_WAIT;
                    if (dir == DIR_L2M) begin
                        l_en <= 1'b0;
                    end else if (m_ack) begin
                        data  <= m_rdata;
                        m_req <= 1'b0;
                        got   <= 1'b1;
                    end
                end
                SRC_WAIT: begin
                    if (dir == DIR_L2M) begin
                        data  <= l_rdata;
                        m_req <= 1'b1;
                        m_we  <= 1'b1;
                        state <= DST;
                    end else if (got || m_ack) begin
                        // An early ack already captured the word; a late ack with m_req low is ignored.
                        if (!got) data <= m_rdata;
                        got   <= 1'b0;
                        m_req <= 1'b0;
                        l_we  <= 1'b1;
                        state <= DST;
                    end
                end
                DST: begin
                    l_we <= 1'b0;
                    if (step) begin
                        m_req  <= 1'b0;
                        m_we   <= 1'b0;
                        cnt    <= cnt - WIDTH'(1);
                        m_addr <= m_addr + WIDTH'(4);
                        l_addr <= l_addr + LANE_AWIDTH'(1);
                        if (cnt == WIDTH'(1)) begin
                            dma_done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= SRC;
                            if (dir == DIR_L2M) l_en  <= 1'b1;
                            else                m_req <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    dma_done <= 1'b0;
                    dma_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/vdma_controller.md
VDMA_CONTROLLER -- requirements
Module: vdma_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data, address and count width.
REQ-002 SHALL have parameter LANE_AWIDTH, default 10, meaning lane-local memory word-address width.
REQ-003 SHALL have `clk`, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have `reset`, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have `dma_en`, input, 1 bit: start request, a level from control register 30 bit 0.
REQ-006 SHALL have `dma_we`, input, 1 bit: direction; 0 = memory to lane, 1 = lane to memory.
REQ-007 SHALL have `mem_addr`, input, WIDTH bits: main-memory byte start address.
REQ-008 SHALL have `lane_addr`, input, WIDTH bits: lane-memory byte start address.
REQ-009 SHALL have `num_bytes`, input, WIDTH bits: transfer length in bytes; bits [1:0] are always 0.
REQ-010 SHALL have `dma_busy`, output, 1 bit: transfer in progress; fed back to control register 27.
REQ-011 SHALL have `dma_done`, output, 1 bit: one-cycle pulse when a transfer completes.
REQ-012 SHALL have `m_req`, output, 1 bit: memory request.
REQ-013 SHALL have `m_we`, output, 1 bit: memory write.
REQ-014 SHALL have `m_addr`, output, WIDTH bits: memory byte address.
REQ-015 SHALL have `m_wdata`, output, WIDTH bits: memory write data.
REQ-016 SHALL have `m_rdata`, input, WIDTH bits: memory read data, valid when `m_ack` is high.
REQ-017 SHALL have `m_ack`, input, 1 bit: memory accepts or completes the request in that cycle.
REQ-018 SHALL have `l_en`, output, 1 bit: lane-memory read enable.
REQ-019 SHALL have `l_we`, output, 1 bit: lane-memory write enable.
REQ-020 SHALL have `l_addr`, output, LANE_AWIDTH bits: lane-memory word address.
REQ-021 SHALL have `l_wdata`, output, WIDTH bits: lane-memory write data.
REQ-022 SHALL have `l_rdata`, input, WIDTH bits: lane-memory read data, valid 1 cycle after `l_en`.

Function
REQ-023 SHALL start a transfer only on a rising edge of `dma_en` while in IDLE; a held-high `dma_en` does not restart.
REQ-024 SHALL capture `dma_we`, `mem_addr`, `lane_addr[LANE_AWIDTH+1:2]` and word count `num_bytes>>2` at the start edge; input changes during a transfer are ignored.
REQ-025 SHALL treat a word count of 0 as a no-op: stay in IDLE, no `dma_busy`, no `dma_done`.
REQ-026 SHALL use exactly the states IDLE, SRC, SRC_WAIT, DST and DONE.
REQ-027 SHALL take the transitions IDLE->SRC on start; SRC->SRC_WAIT; SRC_WAIT->DST on data captured; DST->SRC if words remain, DST->DONE on the last word; DONE->IDLE.
REQ-028 SHALL, for dma_we=0: in SRC assert `m_req=1, m_we=0`, held until `m_ack`, and latch `m_rdata` on `m_ack`; in DST pulse `l_we` for 1 cycle.
REQ-029 SHALL, for dma_we=1: in SRC pulse `l_en` for 1 cycle, latch `l_rdata` in SRC_WAIT, and in DST hold `m_req=1, m_we=1` until `m_ack`.
REQ-030 SHALL keep `m_addr`, `m_we` and `m_wdata` stable while `m_req` is high and `m_ack` is low.
REQ-031 SHALL advance the memory address by +4 and the lane word address by +1 per word; the lane address wraps modulo 2^LANE_AWIDTH and the memory address wraps modulo 2^WIDTH.
REQ-032 SHALL assert `dma_busy` from the cycle after the start edge until DONE inclusive, and pulse `dma_done` in DONE.
REQ-033 SHALL ignore an `m_ack` that arrives while `m_req` is low.
REQ-034 SHALL ignore a new `dma_en` rising edge during a transfer (no queueing).

Reset
REQ-035 SHALL, on `reset` high at a clock edge, enter IDLE from any state, abandoning any transfer in flight.
REQ-036 SHALL drive these reset values: `dma_busy`, `dma_done`, `m_req`, `m_we`, `l_en` and `l_we` = 0; address, data and count registers = 0; the `dma_en` edge-detect register = 0.
REQ-037 SHALL treat `dma_en` already high when reset releases as a rising edge on the first post-reset cycle.

Structure
REQ-038 SHALL place the state encoding (IDLE..DONE) and the direction constants DIR_M2L/DIR_L2M in the shared vector package.
REQ-039 SHALL be a single module with no sub-modules; the word counter and address incrementers are inline.

Verification
REQ-040 SHALL cover memory to lane: mem_addr=0x100, lane_addr=0x20, num_bytes=16, m_ack 1 cycle after each m_req -> m_addr 0x100/104/108/10C, l_addr 8/9/10/11, 4 l_we pulses with data matching, dma_done once.
REQ-041 SHALL cover lane to memory: num_bytes=8, dma_we=1, m_ack delayed 3 cycles -> m_req/m_addr/m_wdata held stable 3 cycles, 2 memory writes, busy low after DONE.
REQ-042 SHALL cover num_bytes=0 with a dma_en edge -> dma_busy stays 0 and no m_req/l_en.
REQ-043 SHALL cover reset asserted in SRC_WAIT of word 2 -> next cycle all outputs 0 in IDLE; a fresh dma_en edge restarts from the newly captured addresses.
REQ-044 SHALL cover dma_en held high across completion, and a second edge mid-transfer -> exactly one transfer.
REQ-045 SHALL cover lane wrap: lane_addr word 2^LANE_AWIDTH-1 with num_bytes=8 -> l_addr max, then 0.
